rsa_key_manager: RTL and testbench

- Sits downstream of EnD_KeyGenerator.
- Accepts (phi, n) from the prime stage and drives the generator's en/phi.
- Captures the single-cycle e_key/d_key strobes into a shadow pair, range-checks them, and commits them to the active key registers used by the encrypt/decrypt engine.
- Commit is deferred while the engine holds key_lock; the old pair stays active until a clean commit. Timeout and error reporting are included.

---
 rtl/rsa_pkg.sv | 31 +++
 rtl/key_timeout_counter.sv | 48 ++++
 rtl/rsa_key_manager.sv | 210 +++++++++++++++++++++
 tb/tb_rsa_key_manager.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA key manager slice.
//   RSA_WIDTH  default key / modulus width (must match EnD_KeyGenerator)
//   MIN_PHI    smallest totient that can hold a valid exponent pair
//   state_e    key manager FSM states
//   ERR_*      values reported on err_code
// ---------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    // phi below 3 leaves no room for 0 < e,d < phi with e != 1 being useful,
    // so such a totient is rejected before the generator is started.
    localparam int unsigned MIN_PHI = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_PEND,
        ST_READY,
        ST_ERROR
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_MISMATCH = 3'd2;
    localparam logic [2:0] ERR_RANGE    = 3'd3;
    localparam logic [2:0] ERR_BAD_PHI  = 3'd4;

endpackage

// File: rtl/key_timeout_counter.sv
// ---------------------------------------------------------------------------
// key_timeout_counter
// Counts cycles spent waiting on the key generator and flags when the
// budget is exhausted.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clear_i    restart the count at zero (has priority over enable_i)
//   enable_i   advance the count by one this cycle
//   expired_o  count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module key_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is judged on the registered count, so the abort lands exactly
    // TIMEOUT_CYCLES edges after the count was cleared.
    assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/rsa_key_manager.sv
// ---------------------------------------------------------------------------
// rsa_key_manager
// Drives EnD_KeyGenerator with a new totient, captures the returned e/d
// strobes into a shadow pair, range-checks them and commits them (with the
// pending modulus) to the active key registers once the engine releases
// key_lock.
//   clk, rst_n            clock / asynchronous active-low reset
//   phi_valid, phi_in,
//   n_in                  new totient and modulus from the prime stage
//   kg_en, kg_phi         generator enable and held totient
//   e_key_valid, e_key,
//   d_key_valid, d_key    generator result strobes
//   key_lock              engine busy; defers commit
//   pub_e, pub_n, priv_d  active key pair and modulus
//   keys_ready            an active pair exists
//   key_update            one-cycle pulse on each commit
//   key_epoch             commit counter (wraps)
//   busy                  generation or commit outstanding
//   err, err_code         error state and cause
// ---------------------------------------------------------------------------
module rsa_key_manager
    import rsa_pkg::*;
#(
    parameter int WIDTH          = RSA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phi_valid,
    input  logic [WIDTH-1:0] phi_in,
    input  logic [WIDTH-1:0] n_in,
    output logic             kg_en,
    output logic [WIDTH-1:0] kg_phi,
    input  logic             e_key_valid,
    input  logic [WIDTH-1:0] e_key,
    input  logic             d_key_valid,
    input  logic [WIDTH-1:0] d_key,
    input  logic             key_lock,
    output logic [WIDTH-1:0] pub_e,
    output logic [WIDTH-1:0] pub_n,
    output logic [WIDTH-1:0] priv_d,
    output logic             keys_ready,
    output logic             key_update,
    output logic [7:0]       key_epoch,
    output logic             busy,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam logic [WIDTH-1:0] PHI_MIN = WIDTH'(MIN_PHI);

    state_e           state_q,     state_d;
    logic             kgEn_q,      kgEn_d;
    logic [WIDTH-1:0] kgPhi_q,     kgPhi_d;
    logic [WIDTH-1:0] nPending_q,  nPending_d;
    logic [WIDTH-1:0] shadowE_q,   shadowE_d;
    logic [WIDTH-1:0] shadowD_q,   shadowD_d;
    logic [WIDTH-1:0] pubE_q,      pubE_d;
    logic [WIDTH-1:0] pubN_q,      pubN_d;
    logic [WIDTH-1:0] privD_q,     privD_d;
    logic             keysReady_q, keysReady_d;
    logic             keyUpdate_q, keyUpdate_d;
    logic [7:0]       keyEpoch_q,  keyEpoch_d;
    logic [2:0]       errCode_q,   errCode_d;

    logic cntClear;
    logic cntEnable;
    logic cntExpired;
    logic rangeFail;

    key_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cntClear),
        .enable_i  (cntEnable),
        .expired_o (cntExpired)
    );

    // Both exponents must lie strictly between 0 and the totient they were
    // generated for.
    assign rangeFail = (e_key == '0) || (d_key == '0) ||
                       (e_key >= kgPhi_q) || (d_key >= kgPhi_q);

    always_comb begin
        state_d     = state_q;
        kgEn_d      = kgEn_q;
        kgPhi_d     = kgPhi_q;
        nPending_d  = nPending_q;
        shadowE_d   = shadowE_q;
        shadowD_d   = shadowD_q;
        pubE_d      = pubE_q;
        pubN_d      = pubN_q;
        privD_d     = privD_q;
        keysReady_d = keysReady_q;
        keyUpdate_d = 1'b0;
        keyEpoch_d  = keyEpoch_q;
        errCode_d   = errCode_q;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;

        case (state_q)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (phi_valid) begin
                    if (phi_in < PHI_MIN) begin
                        state_d   = ST_ERROR;
                        errCode_d = ERR_BAD_PHI;
                    end else begin
                        state_d    = ST_GEN;
                        kgPhi_d    = phi_in;
                        nPending_d = n_in;
                        kgEn_d     = 1'b1;
                        errCode_d  = ERR_NONE;
                        cntClear   = 1'b1;
                    end
                end
            end

            // A strobe in the expiry cycle still counts; timeout is checked last.
            ST_GEN: begin
                cntEnable = 1'b1;
                if (e_key_valid ^ d_key_valid) begin
                    state_d   = ST_ERROR;
                    errCode_d = ERR_MISMATCH;
                    kgEn_d    = 1'b0;
                end else if (e_key_valid && d_key_valid) begin
                    shadowE_d = e_key;
                    shadowD_d = d_key;
                    kgEn_d    = 1'b0;
                    if (rangeFail) begin
                        state_d   = ST_ERROR;
                        errCode_d = ERR_RANGE;
                    end else begin
                        state_d = ST_PEND;
                    end
                end else if (cntExpired) begin
                    state_d   = ST_ERROR;
                    errCode_d = ERR_TIMEOUT;
                    kgEn_d    = 1'b0;
                end
            end

            // The modulus is committed together with its exponents so the
            // engine never sees a mixed old/new key set.
            ST_PEND: begin
                if (!key_lock) begin
                    pubE_d      = shadowE_q;
                    privD_d     = shadowD_q;
                    pubN_d      = nPending_q;
                    keysReady_d = 1'b1;
                    keyUpdate_d = 1'b1;
                    keyEpoch_d  = keyEpoch_q + 8'd1;
                    state_d     = ST_READY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kgEn_q      <= 1'b0;
            kgPhi_q     <= '0;
            nPending_q  <= '0;
            shadowE_q   <= '0;
            shadowD_q   <= '0;
            pubE_q      <= '0;
            pubN_q      <= '0;
            privD_q     <= '0;
            keysReady_q <= 1'b0;
            keyUpdate_q <= 1'b0;
            keyEpoch_q  <= 8'd0;
            errCode_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            kgEn_q      <= kgEn_d;
            kgPhi_q     <= kgPhi_d;
            nPending_q  <= nPending_d;
            shadowE_q   <= shadowE_d;
            shadowD_q   <= shadowD_d;
            pubE_q      <= pubE_d;
            pubN_q      <= pubN_d;
            privD_q     <= privD_d;
            keysReady_q <= keysReady_d;
            keyUpdate_q <= keyUpdate_d;
            keyEpoch_q  <= keyEpoch_d;
            errCode_q   <= errCode_d;
        end
    end

    assign kg_en      = kgEn_q;
    assign kg_phi     = kgPhi_q;
    assign pub_e      = pubE_q;
    assign pub_n      = pubN_q;
    assign priv_d     = privD_q;
    assign keys_ready = keysReady_q;
    assign key_update = keyUpdate_q;
    assign key_epoch  = keyEpoch_q;
    assign err_code   = errCode_q;
    assign busy       = (state_q == ST_GEN) || (state_q == ST_PEND);
    assign err        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_rsa_key_manager.sv
// ---------------------------------------------------------------------------
// tb_rsa_key_manager
// Self-checking bench for rsa_key_manager. The stimulus process plays the
// prime stage, the key generator and the engine, and pushes the outcome it
// expects for each generation into a queue. A monitor pops that queue every
// time the DUT commits a pair or enters/changes an error.
// ---------------------------------------------------------------------------
module tb_rsa_key_manager;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          phi_valid;
    logic [W-1:0]  phi_in;
    logic [W-1:0]  n_in;
    logic          kg_en;
    logic [W-1:0]  kg_phi;
    logic          e_key_valid;
    logic [W-1:0]  e_key;
    logic          d_key_valid;
    logic [W-1:0]  d_key;
    logic          key_lock;
    logic [W-1:0]  pub_e;
    logic [W-1:0]  pub_n;
    logic [W-1:0]  priv_d;
    logic          keys_ready;
    logic          key_update;
    logic [7:0]    key_epoch;
    logic          busy;
    logic          err;
    logic [2:0]    err_code;

    rsa_key_manager #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phi_valid   (phi_valid),
        .phi_in      (phi_in),
        .n_in        (n_in),
        .kg_en       (kg_en),
        .kg_phi      (kg_phi),
        .e_key_valid (e_key_valid),
        .e_key       (e_key),
        .d_key_valid (d_key_valid),
        .d_key       (d_key),
        .key_lock    (key_lock),
        .pub_e       (pub_e),
        .pub_n       (pub_n),
        .priv_d      (priv_d),
        .keys_ready  (keys_ready),
        .key_update  (key_update),
        .key_epoch   (key_epoch),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    // Expected observable event: either a commit or an error entry.
    typedef struct {
        bit         isCommit;
        logic [2:0] code;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [7:0] epoch;
        bit         ready;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model: the key set the engine should currently see.
    logic [W-1:0] modelE;
    logic [W-1:0] modelN;
    logic [W-1:0] modelD;
    logic [7:0]   modelEpoch;
    bit           modelReady;
    bit           lastBadPhi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] watchdog expired, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelE     = '0;
        modelN     = '0;
        modelD     = '0;
        modelEpoch = 8'd0;
        modelReady = 1'b0;
        lastBadPhi = 1'b0;
    endtask

    task automatic pushError(input logic [2:0] code);
        exp_t x;
        x.isCommit = 1'b0;
        x.code     = code;
        x.e        = modelE;
        x.n        = modelN;
        x.d        = modelD;
        x.epoch    = modelEpoch;
        x.ready    = modelReady;
        expQ.push_back(x);
    endtask

    task automatic pushCommit(input logic [W-1:0] e, input logic [W-1:0] n,
                              input logic [W-1:0] d);
        exp_t x;
        modelE     = e;
        modelN     = n;
        modelD     = d;
        modelEpoch = modelEpoch + 8'd1;
        modelReady = 1'b1;
        x.isCommit = 1'b1;
        x.code     = 3'd0;
        x.e        = e;
        x.n        = n;
        x.d        = d;
        x.epoch    = modelEpoch;
        x.ready    = 1'b1;
        expQ.push_back(x);
    endtask

    task automatic waitNotBusy();
        int cnt;
        cnt = 0;
        while (busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("waitNotBusy", {31'd0, busy}, 32'd0);
    endtask

    // One generation request. mode: 0 both strobes, 1 only e, 2 only d,
    // 3 generator never answers.
    task automatic applyStimulus(input logic [W-1:0] phi, input logic [W-1:0] n,
                                 input logic [W-1:0] e, input logic [W-1:0] d,
                                 input int delay, input int lockCycles, input int mode);
        bit willCommit;
        logic [W-1:0] oldE;
        logic [W-1:0] oldN;
        logic [W-1:0] oldD;
        @(negedge clk);
        phi_valid = 1'b1;
        phi_in    = phi;
        n_in      = n;
        if (phi < 3) begin
            pushError(3'd4);
            lastBadPhi = 1'b1;
            @(negedge clk);
            phi_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checkOutput("kgEnBadPhi", {31'd0, kg_en}, 32'd0);
                @(negedge clk);
            end
            return;
        end
        lastBadPhi = 1'b0;
        @(negedge clk);
        phi_valid = 1'b0;
        checkOutput("kgEnRise", {31'd0, kg_en}, 32'd1);
        checkOutput("kgPhi", kg_phi, phi);
        checkOutput("busyGen", {31'd0, busy}, 32'd1);
        checkOutput("errCodeCleared", {29'd0, err_code}, 32'd0);

        if (mode == 3) begin
            repeat (63) @(negedge clk);
            checkOutput("preTimeoutErr", {31'd0, err}, 32'd0);
            checkOutput("preTimeoutKgEn", {31'd0, kg_en}, 32'd1);
            pushError(3'd1);
            @(negedge clk);
            checkOutput("timeoutKgEn", {31'd0, kg_en}, 32'd0);
            checkOutput("timeoutErr", {31'd0, err}, 32'd1);
            e_key_valid = 1'b1;
            d_key_valid = 1'b1;
            e_key       = 32'd1;
            d_key       = 32'd1;
            @(negedge clk);
            e_key_valid = 1'b0;
            d_key_valid = 1'b0;
            checkOutput("strayCode", {29'd0, err_code}, 32'd1);
            checkOutput("strayPubE", pub_e, modelE);
            return;
        end

        repeat (delay - 1) @(negedge clk);
        oldE = modelE;
        oldN = modelN;
        oldD = modelD;
        e_key_valid = (mode != 2);
        d_key_valid = (mode != 1);
        e_key       = e;
        d_key       = d;
        key_lock    = (lockCycles > 0);
        // A bad totient offered while busy must be ignored.
        phi_valid   = 1'b1;
        phi_in      = 32'd1;
        willCommit  = 1'b0;
        if (mode != 0) begin
            pushError(3'd2);
        end else if (e == 0 || d == 0 || e >= phi || d >= phi) begin
            pushError(3'd3);
        end else begin
            pushCommit(e, n, d);
            willCommit = 1'b1;
        end
        @(negedge clk);
        e_key_valid = 1'b0;
        d_key_valid = 1'b0;
        checkOutput("kgEnFall", {31'd0, kg_en}, 32'd0);
        if (willCommit && lockCycles > 0) begin
            for (int i = 0; i < lockCycles; i++) begin
                checkOutput("pendBusy", {31'd0, busy}, 32'd1);
                checkOutput("pendHoldE", pub_e, oldE);
                checkOutput("pendHoldN", pub_n, oldN);
                checkOutput("pendHoldD", priv_d, oldD);
                checkOutput("pendNoUpdate", {31'd0, key_update}, 32'd0);
                @(negedge clk);
            end
        end
        phi_valid = 1'b0;
        key_lock  = 1'b0;
        waitNotBusy();
    endtask

    task automatic compareEvent(input bit isCommit);
        exp_t x;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent commit=%0d code=%0d required no event at %0t",
                     isCommit, err_code, $time);
            return;
        end
        x = expQ.pop_front();
        checkOutput("eventKind", {31'd0, isCommit}, {31'd0, x.isCommit});
        if (!isCommit) begin
            checkOutput("errCode", {29'd0, err_code}, {29'd0, x.code});
        end
        checkOutput("pubE", pub_e, x.e);
        checkOutput("pubN", pub_n, x.n);
        checkOutput("privD", priv_d, x.d);
        checkOutput("keyEpoch", {24'd0, key_epoch}, {24'd0, x.epoch});
        checkOutput("keysReady", {31'd0, keys_ready}, {31'd0, x.ready});
    endtask

    // Monitor: every commit pulse and every new error is matched in order.
    initial begin
        bit         prevErr;
        logic [2:0] prevCode;
        prevErr  = 1'b0;
        prevCode = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevErr  = 1'b0;
                prevCode = 3'd0;
            end else begin
                if (key_update) compareEvent(1'b1);
                if (err && (!prevErr || err_code != prevCode)) compareEvent(1'b0);
                prevErr  = err;
                prevCode = err_code;
            end
        end
    end

    initial begin
        logic [W-1:0] phi, n, e, d;
        int sel, mode, delay, lockCycles;

        rst_n       = 1'b0;
        phi_valid   = 1'b0;
        phi_in      = '0;
        n_in        = '0;
        e_key_valid = 1'b0;
        e_key       = '0;
        d_key_valid = 1'b0;
        d_key       = '0;
        key_lock    = 1'b0;
        resetModel();

        #3;
        checkOutput("rstKgEn", {31'd0, kg_en}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstErr", {31'd0, err}, 32'd0);
        checkOutput("rstKeysReady", {31'd0, keys_ready}, 32'd0);
        checkOutput("rstEpoch", {24'd0, key_epoch}, 32'd0);
        checkOutput("rstPubE", pub_e, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed: basic commit");
        applyStimulus(32'd3120, 32'd3233, 32'd17, 32'd2753, 40, 0, 0);
        checkOutput("t1PubE", pub_e, 32'd17);
        checkOutput("t1PrivD", priv_d, 32'd2753);
        checkOutput("t1PubN", pub_n, 32'd3233);
        checkOutput("t1Epoch", {24'd0, key_epoch}, 32'd1);

        $display("[TB] directed: range failure keeps old keys");
        applyStimulus(32'd8640, 32'd8987, 32'd5000, 32'd9000, 12, 0, 0);
        checkOutput("t3ErrCode", {29'd0, err_code}, 32'd3);
        checkOutput("t3PubE", pub_e, 32'd17);
        checkOutput("t3KeysReady", {31'd0, keys_ready}, 32'd1);

        $display("[TB] directed: commit deferred by key_lock");
        applyStimulus(32'd3120, 32'd3233, 32'd7, 32'd1783, 40, 10, 0);
        checkOutput("t2PubE", pub_e, 32'd7);
        checkOutput("t2Epoch", {24'd0, key_epoch}, 32'd2);

        $display("[TB] directed: timeout, mismatch, bad phi");
        applyStimulus(32'd3120, 32'd3233, 32'd17, 32'd2753, 1, 0, 3);
        applyStimulus(32'd3120, 32'd3233, 32'd17, 32'd2753, 10, 0, 1);
        applyStimulus(32'd2, 32'd3233, 32'd17, 32'd2753, 1, 0, 0);
        checkOutput("t5ErrCode", {29'd0, err_code}, 32'd4);

        $display("[TB] random generations");
        for (int i = 0; i < 30; i++) begin
            sel        = $urandom_range(9, 0);
            phi        = $urandom_range(32'hFFFF_FFF0, 3);
            n          = $urandom;
            e          = $urandom_range(phi - 1, 1);
            d          = $urandom_range(phi - 1, 1);
            mode       = 0;
            delay      = $urandom_range(50, 1);
            lockCycles = ($urandom_range(1, 0) == 1) ? $urandom_range(5, 1) : 0;
            if (sel == 0 && !lastBadPhi) begin
                phi = $urandom_range(2, 0);
            end else if (sel == 1) begin
                mode = 1;
            end else if (sel == 2) begin
                mode = 2;
            end else if (sel == 3) begin
                case ($urandom_range(3, 0))
                    0: e = '0;
                    1: d = '0;
                    2: e = phi;
                    default: d = phi + $urandom_range(10, 0);
                endcase
            end else if (sel == 4) begin
                mode = 3;
            end
            applyStimulus(phi, n, e, d, delay, lockCycles, mode);
        end

        $display("[TB] reset during generation");
        @(negedge clk);
        phi_valid = 1'b1;
        phi_in    = 32'd3120;
        n_in      = 32'd3233;
        @(negedge clk);
        phi_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstKgEn", {31'd0, kg_en}, 32'd0);
        checkOutput("midRstKgPhi", kg_phi, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstPubE", pub_e, 32'd0);
        checkOutput("midRstPubN", pub_n, 32'd0);
        checkOutput("midRstPrivD", priv_d, 32'd0);
        checkOutput("midRstKeysReady", {31'd0, keys_ready}, 32'd0);
        checkOutput("midRstEpoch", {24'd0, key_epoch}, 32'd0);
        checkOutput("midRstErrCode", {29'd0, err_code}, 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] epoch wrap");
        for (int i = 0; i < 256; i++) begin
            phi = $urandom_range(32'h00FF_FFFF, 3);
            applyStimulus(phi, $urandom, $urandom_range(phi - 1, 1),
                          $urandom_range(phi - 1, 1), $urandom_range(3, 1),
                          $urandom_range(2, 0), 0);
        end
        checkOutput("epochWrap", {24'd0, key_epoch}, 32'd0);
        checkOutput("epochWrapReady", {31'd0, keys_ready}, 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
